// File: rtl/mult2_accum.sv
// Multiply-accumulate back end for the 2-bit multiplier: sums 4-bit products
// into a registered accumulator and hands the result off over valid/ready.
module mult2_accum #(
    parameter int ACC_W     = 8,
    parameter int MAX_TERMS = 16,
    parameter int SATURATE  = 1,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       prod,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic               r_in_ready;
    logic               w_in_ready_nxt;

    logic               w_in_beat;
    logic               w_out_beat;
    logic [ACC_W:0]     w_sum;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_close_first;
    logic               w_close_acc;

    assign w_in_beat  = in_valid & r_in_ready;
    assign w_out_beat = r_out_valid & out_ready;
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, prod};
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    assign w_close_first = in_last || (MAX_TERMS == 1);
    assign w_close_acc   = in_last || (w_cnt_inc == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_beat) begin
                    w_state_nxt = w_close_first ? S_DONE : S_ACC;
                end
            end
            S_ACC: begin
                if (w_in_beat) begin
                    w_state_nxt = w_close_acc ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (w_out_beat) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result registers hold through DONE and IDLE until the next first-term load.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        w_cnt_nxt = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_beat) begin
                    w_acc_nxt = {{(ACC_W-4){1'b0}}, prod};
                    w_ovf_nxt = 1'b0;
                    w_cnt_nxt = CNT_W'(1);
                end
            end
            S_ACC: begin
                if (w_in_beat) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_sum[ACC_W]) begin
                        w_ovf_nxt = 1'b1;
                        w_acc_nxt = (SATURATE != 0) ? {ACC_W{1'b1}}
                                                    : w_sum[ACC_W-1:0];
                    end else begin
                        w_acc_nxt = w_sum[ACC_W-1:0];
                    end
                end
            end
            default: ;
        endcase
        w_out_valid_nxt = (w_state_nxt == S_DONE);
        w_in_ready_nxt  = (w_state_nxt != S_DONE);
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign acc_ovf   = r_ovf;
    assign acc_cnt   = r_cnt;

endmodule

// File: tb/tb_mult2_accum.sv
// Bench for mult2_accum: three configurations share one stimulus stream and
// are compared each cycle against an arithmetic model of the vector sum.
module tb_mult2_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] prod;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic       ir_a, ir_b, ir_c;
    logic       ov_a, ov_b, ov_c;
    logic       of_a, of_b, of_c;
    logic [7:0] acc_a;
    logic [4:0] acc_b, acc_c;
    logic [4:0] cnt_a, cnt_b, cnt_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult2_accum u_a (
        .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir_a), .acc_out(acc_a), .acc_ovf(of_a),
        .acc_cnt(cnt_a), .out_valid(ov_a), .out_ready(out_ready)
    );

    mult2_accum #(.ACC_W(5), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir_b), .acc_out(acc_b), .acc_ovf(of_b),
        .acc_cnt(cnt_b), .out_valid(ov_b), .out_ready(out_ready)
    );

    mult2_accum #(.ACC_W(5), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir_c), .acc_out(acc_c), .acc_ovf(of_c),
        .acc_cnt(cnt_c), .out_valid(ov_c), .out_ready(out_ready)
    );

    logic [7:0] g_acc [3];
    logic [4:0] g_cnt [3];
    logic       g_ir  [3];
    logic       g_ov  [3];
    logic       g_of  [3];
    assign g_acc[0] = acc_a;
    assign g_acc[1] = {3'b000, acc_b};
    assign g_acc[2] = {3'b000, acc_c};
    assign g_cnt[0] = cnt_a;
    assign g_cnt[1] = cnt_b;
    assign g_cnt[2] = cnt_c;
    assign g_ir[0] = ir_a;
    assign g_ir[1] = ir_b;
    assign g_ir[2] = ir_c;
    assign g_ov[0] = ov_a;
    assign g_ov[1] = ov_b;
    assign g_ov[2] = ov_c;
    assign g_of[0] = of_a;
    assign g_of[1] = of_b;
    assign g_of[2] = of_c;

    int cfg_w [3] = '{8, 5, 5};
    bit cfg_s [3] = '{1'b1, 1'b1, 1'b0};

    // Model: exact (unbounded) running total of the current vector.
    bit m_started;
    bit m_done;
    bit m_open;
    int m_total;
    int m_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_acc(input int k);
        int lim;
        lim = 1 << cfg_w[k];
        if (m_total < lim) return m_total;
        return cfg_s[k] ? lim - 1 : m_total % lim;
    endfunction

    function automatic bit exp_ovf(input int k);
        return m_total >= (1 << cfg_w[k]);
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_done    = 0;
        m_open    = 0;
        m_total   = 0;
        m_cnt     = 0;
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s in_ready[%0d]", tag, k), 32'(g_ir[k]),
                  32'(m_started && !m_done));
            check($sformatf("%s out_valid[%0d]", tag, k), 32'(g_ov[k]),
                  32'(m_done));
            check($sformatf("%s acc_out[%0d]", tag, k), 32'(g_acc[k]),
                  32'(exp_acc(k)));
            check($sformatf("%s acc_ovf[%0d]", tag, k), 32'(g_of[k]),
                  32'(exp_ovf(k)));
            check($sformatf("%s acc_cnt[%0d]", tag, k), 32'(g_cnt[k]),
                  32'(m_cnt));
        end
    endtask

    task automatic model_edge(input logic v, input logic l,
                              input logic [3:0] p, input logic ordy);
        if (!m_started) begin
            m_started = 1;
        end else if (m_done) begin
            if (ordy) m_done = 0;
        end else if (v) begin
            if (!m_open) begin
                m_total = int'(p);
                m_cnt   = 1;
                m_open  = 1;
            end else begin
                m_total += int'(p);
                m_cnt++;
            end
            if (l || m_cnt == 16) begin
                m_done = 1;
                m_open = 0;
            end
        end
    endtask

    // Called at a falling edge: check, drive, advance the model over the rising edge.
    task automatic step(input string tag, input logic v, input logic l,
                        input logic [3:0] p, input logic ordy);
        check_all(tag);
        in_valid  = v;
        in_last   = l;
        prod      = p;
        out_ready = ordy;
        @(posedge clk);
        model_edge(v, l, p, ordy);
        @(negedge clk);
    endtask

    initial begin
        logic       v, l, o;
        logic [3:0] p;
        int         last_mod;
        rst_n     = 1'b0;
        prod      = 4'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        step("rst", 1, 0, 4'd9, 0);
        step("t2", 1, 1, 4'd9, 0);
        step("t2h", 0, 0, 4'd0, 1);

        step("t3", 1, 0, 4'd9, 0);
        step("t3", 1, 0, 4'd6, 0);
        step("t3", 1, 0, 4'd4, 0);
        step("t3", 1, 1, 4'd1, 0);
        repeat (3) step("t3stall", 1, 0, 4'd7, 0);
        step("t3rel", 0, 0, 4'd0, 1);

        repeat (4) step("t4", 1, 0, 4'd9, 0);
        step("t4", 1, 1, 4'd9, 0);
        step("t4rel", 0, 0, 4'd0, 1);

        repeat (17) step("t5", 1, 0, 4'd1, 0);
        step("t6", 1, 0, 4'd3, 1);
        step("t6", 1, 0, 4'd2, 0);

        step("t1", 1, 0, 4'd9, 1);
        step("t1", 1, 0, 4'd9, 0);
        step("t1", 1, 0, 4'd3, 0);
        check_all("t1pre");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t1 async acc_out", 32'(acc_a), 32'd0);
        check("t1 async out_valid", 32'(ov_a), 32'd0);
        check("t1 async in_ready", 32'(ir_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            last_mod = (i < 1500) ? 4 : 30;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, last_mod - 1) == 0);
            if ($urandom_range(0, 7) == 0) p = 4'($urandom_range(10, 15));
            else p = 4'($urandom_range(0, 9));
            o = ($urandom_range(0, 1) != 0);
            step("rnd", v, l, p, o);
        end
        check_all("end");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
